// File: rtl/core_pkg.sv
// Shared fetch/decode/imem types: address and instruction widths plus the canonical NOP.
package core_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // addi x0, x0, 0
  localparam instr_t NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, drives imem, 1-cycle fetch latency, 1-bubble redirect penalty.
// Decode back-pressure (stall_i) freezes PC and the imem data register; a redirect overrides it.
module ifetch
  import core_pkg::addr_t;
  import core_pkg::instr_t;
#(
  parameter addr_t  RESET_PC  = 16'h0000,
  parameter instr_t NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_stall,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        misalign_o,
  output logic [31:0] fetch_count
);

  addr_t  fetch_pc;
  addr_t  pc_q;
  logic   valid_q;
  logic   misalign_q;
  logic   accept;
  addr_t  next_fetch_pc;
  addr_t  next_pc_q;
  logic   next_valid;

  assign accept = valid_q & ~stall_i & ~redirect_valid;

  // Next-PC mux: redirect beats stall beats sequential advance.
  always_comb begin
    next_fetch_pc = fetch_pc + 16'd4;
    next_pc_q     = fetch_pc;
    next_valid    = 1'b1;
    if (redirect_valid) begin
      next_fetch_pc = {redirect_pc[15:2], 2'b00};
      next_valid    = 1'b0;
    end else if (stall_i) begin
      next_fetch_pc = fetch_pc;
      next_pc_q     = pc_q;
      next_valid    = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      fetch_pc   <= next_fetch_pc;
      pc_q       <= next_pc_q;
      valid_q    <= next_valid;
      misalign_q <= redirect_valid & (|redirect_pc[1:0]);
      if (accept) fetch_count <= fetch_count + 32'd1;
    end
  end

  // Never freeze imem on a redirect: the wrong-path word must be overwritten next edge.
  assign imem_stall = stall_i & ~redirect_valid & ~reset;
  assign imem_addr  = fetch_pc;
  assign instr_out  = valid_q ? imem_data : NOP_INSTR;
  assign pc_out     = pc_q;
  assign valid_out  = valid_q;
  assign misalign_o = misalign_q;

endmodule
